// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module   : fetch_sequencer
// Brief    : Owns PC and IR, fetches opcodes from instruction memory and steps
//            the EXEC / MEM / HALT phases from the decoder's state_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_sequencer #(
    parameter int              PC_W     = 4,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic [7:0]      opcode,
    output logic            opcode_valid,
    input  logic [1:0]      state_control,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_target,
    input  logic            resume,
    output logic            exec_en,
    output logic            mem_phase,
    output logic            mem_write,
    output logic            halted,
    output logic [PC_W-1:0] pc
);

    localparam logic [2:0] ST_RST   = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [1:0] SC_SINGLE = 2'b00;
    localparam logic [1:0] SC_HALT   = 2'b11;
    localparam logic [1:0] SC_WRITE  = 2'b10;

    logic [2:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [7:0]      ir_q, ir_d;
    logic [1:0]      sc_q, sc_d;

    // State register together with the PC / IR / latched decoder response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            sc_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            sc_q    <= sc_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        sc_d    = sc_q;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_valid) begin
                    ir_d    = imem_data;
                    pc_d    = pc_q + PC_W'(1);
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                sc_d = state_control;
                // A taken branch replaces the increment made during the fetch.
                if (branch_en) begin
                    pc_d = branch_target;
                end
                if (state_control == SC_SINGLE) begin
                    state_d = ST_FETCH;
                end else if (state_control == SC_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_MEM;
                end
            end
            ST_MEM: begin
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // Outputs decode from registered state only.
    always_comb begin
        imem_req     = 1'b0;
        opcode_valid = 1'b0;
        exec_en      = 1'b0;
        mem_phase    = 1'b0;
        mem_write    = 1'b0;
        halted       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
            end
            ST_EXEC: begin
                exec_en      = 1'b1;
                opcode_valid = 1'b1;
            end
            ST_MEM: begin
                mem_phase    = 1'b1;
                opcode_valid = 1'b1;
                mem_write    = (sc_q == SC_WRITE);
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign opcode    = ir_q;

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction fetch and sequencing stage directly upstream of the instruction decoder.
- Owns the program counter (PC) and the instruction register (IR), and fetches opcodes over a request/valid handshake to instruction memory.
- Presents the held opcode to the decoder, then steps the execute/memory/halt phases using the decoder's 2-bit state_control response.
- Generates the one-cycle execute and memory-phase strobes that qualify register-bank and data-memory writes.

Parameters:
- PC_W, 4, program counter / instruction address width in bits.
- RESET_PC, 0, PC value loaded on reset (PC_W bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  PC_W  fetch address; equals PC.
- imem_valid  input  1  instruction memory returns imem_data this cycle.
- imem_data  input  8  fetched opcode byte.
- opcode  output  8  IR contents, driven to the decoder.
- opcode_valid  output  1  opcode is a live instruction (EXEC or MEM state).
- state_control  input  2  decoder response: 00 single-cycle, 01 memory read, 10 memory write, 11 halt.
- branch_en  input  1  load PC from branch_target; honoured only in EXEC.
- branch_target  input  PC_W  branch destination.
- resume  input  1  leave HALT; honoured only in HALT.
- exec_en  output  1  one-cycle execute strobe (register write qualifier).
- mem_phase  output  1  one-cycle memory-access phase strobe.
- mem_write  output  1  write enable for the data memory; high only when mem_phase=1 and the latched state_control is 10.
- halted  output  1  high while in HALT.
- pc  output  PC_W  current PC, for debug.

Behaviour:
- Reset (asynchronous, rst=1): state=RST, PC=RESET_PC, IR=8'h00, latched state_control=00.
  - All outputs are 0, except imem_addr=pc=RESET_PC.
  - Reset asserted in any state, including mid-fetch, abandons that state; a pending imem_valid is ignored.
- States: RST, FETCH, EXEC, MEM, HALT. Encoding is free.
- RST: unconditionally goes to FETCH on the first clock after rst deasserts.
- FETCH:
  - imem_req=1, imem_addr=PC.
  - Stays in FETCH while imem_valid=0; there is no timeout.
  - On imem_valid=1: IR<=imem_data, PC<=PC+1 modulo 2^PC_W (PC=all-ones wraps to 0), then go to EXEC.
  - Fetch latency is 1 cycle when imem_valid is already high in the first FETCH cycle.
- EXEC (exactly one cycle):
  - exec_en=1, opcode_valid=1.
  - state_control is sampled combinationally and latched on exit.
  - 00 -> FETCH; 01 or 10 -> MEM; 11 -> HALT.
  - branch_en=1: PC<=branch_target, overriding the increment done in FETCH. This takes effect for the next fetch in every exit path, including HALT.
- MEM (exactly one cycle):
  - mem_phase=1, opcode_valid=1.
  - mem_write=1 only if the latched state_control is 10.
  - exec_en=0; branch_en is ignored.
  - Always goes to FETCH.
- HALT:
  - halted=1; imem_req=0; opcode holds IR; opcode_valid=0.
  - resume=1 -> FETCH next cycle. Otherwise stays in HALT.
- opcode always equals IR; IR changes only on an accepted fetch.
- Ignored inputs: imem_valid outside FETCH, resume outside HALT, branch_en outside EXEC.
- Throughput per instruction (fetch latency L cycles): L+1 cycles for single-cycle instructions, L+2 for memory instructions.
- All outputs are registered state or decoded from state only, with no combinational path from inputs to outputs. The sole exception is the next-state choice in EXEC, which depends on state_control.

Test Plan:
- Reset and first fetch: assert rst, release, imem_valid held 1, imem_data=8'h05, state_control=00.
  -> Cycle 1 after release: imem_req=1, imem_addr=0.
  -> Next cycle: opcode=8'h05, exec_en=1.
  -> Next cycle: FETCH at imem_addr=1.
- Memory write path: fetch 8'h1A with the decoder returning state_control=10.
  -> EXEC (exec_en=1), then MEM with mem_phase=1 and mem_write=1, then FETCH.
  -> Repeat with state_control=01: mem_write stays 0.
- Fetch stall: imem_valid=0 for 3 cycles.
  -> imem_req=1 and imem_addr stable for those 3 cycles, no exec_en, IR unchanged.
  -> Fourth cycle valid=1: IR loads.
- Branch and wrap: with PC_W=4, run from PC=4'hF.
  -> Next fetch address is 4'h0.
  -> In EXEC with branch_en=1 and branch_target=4'h9, the next imem_addr is 4'h9.
- Halt/resume: state_control=11.
  -> HALT, halted=1, imem_req=0 while resume=0 for 5 cycles.
  -> resume=1: FETCH at the incremented PC.
- Reset mid-operation: assert rst during FETCH with imem_valid=1, and separately during MEM.
  -> Outputs clear immediately (asynchronously), PC returns to RESET_PC, IR=8'h00.
